// File: rtl/ysyx_22051013_ifu_pkg.sv
// ysyx_22051013_ifu_pkg: shared widths, reset PC, FSM encoding and helpers for the fetch unit
package ysyx_22051013_ifu_pkg;
  localparam int IFU_PC_W = 64;
  localparam int IFU_INST_W = 32;
  localparam logic [IFU_PC_W-1:0] IFU_RESET_PC = 64'h8000_0000;
  localparam logic [IFU_PC_W-1:0] IFU_PC_ZERO = '0;
  localparam logic [IFU_INST_W-1:0] IFU_INST_ZERO = '0;
  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_DROP = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_e;
  function automatic logic [IFU_PC_W-1:0] align_word(input logic [IFU_PC_W-1:0] a);
    return {a[IFU_PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ysyx_22051013_ifu_if.sv
// ysyx_22051013_ifu_if: fetch-unit bus bundling the memory request/response channel, redirect and decode handoff
interface ysyx_22051013_ifu_if;
  import ysyx_22051013_ifu_pkg::*;
  logic                  req_valid_o;
  logic                  req_ready_i;
  logic [IFU_PC_W-1:0]   req_addr_o;
  logic                  resp_valid_i;
  logic [IFU_INST_W-1:0] resp_data_i;
  logic                  redirect_i;
  logic [IFU_PC_W-1:0]   redirect_pc_i;
  logic [IFU_INST_W-1:0] inst_o;
  logic [IFU_PC_W-1:0]   pc_o;
  logic                  valid_o;
  logic                  ready_i;
  modport master (
    output req_valid_o, req_addr_o, inst_o, pc_o, valid_o,
    input  req_ready_i, resp_valid_i, resp_data_i, redirect_i, redirect_pc_i, ready_i
  );
  modport slave (
    input  req_valid_o, req_addr_o, inst_o, pc_o, valid_o,
    output req_ready_i, resp_valid_i, resp_data_i, redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/ysyx_22051013_ifu_pcgen.sv
// ysyx_22051013_ifu_pcgen: next-PC selection, redirect target (word aligned) over sequential pc+4
module ysyx_22051013_ifu_pcgen
  import ysyx_22051013_ifu_pkg::*;
#(
  parameter int PC_W = IFU_PC_W
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_next_o
);
  // redirect wins; pc+4 wraps silently at 2^PC_W
  always_comb begin
    pc_next_o = redirect_i ? {redirect_pc_i[PC_W-1:2], 2'b00} :
                advance_i  ? pc_i + PC_W'(4) : pc_i;
  end
endmodule

// File: rtl/ysyx_22051013_ifu.sv
// ysyx_22051013_ifu: single-outstanding instruction fetch FSM with PC and one-entry decode output register
module ysyx_22051013_ifu
  import ysyx_22051013_ifu_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter int              INST_W   = IFU_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = IFU_RESET_PC
) (
  input logic clk,
  input logic rst,
  ysyx_22051013_ifu_if.master bus
);
  ifu_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_out_q, pc_out_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              hs;
  logic              advance;
  assign hs = (state_q == IFU_REQ) && bus.req_ready_i;
  assign advance = (state_q == IFU_WAIT) && bus.resp_valid_i;
  ysyx_22051013_ifu_pcgen #(.PC_W(PC_W)) u_pcgen (
    .pc_i         (pc_q),
    .redirect_i   (bus.redirect_i),
    .redirect_pc_i(bus.redirect_pc_i),
    .advance_i    (advance),
    .pc_next_o    (pc_d)
  );
  // redirect overrides everything; an accepted-but-unanswered request forces DROP so its stale response is swallowed
  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (bus.redirect_i) begin
      valid_d = 1'b0;
      state_d = (state_q == IFU_REQ) ? (hs ? IFU_DROP : IFU_REQ) :
                (state_q == IFU_OUT) ? IFU_REQ :
                (bus.resp_valid_i ? IFU_REQ : IFU_DROP);
    end else begin
      case (state_q)
        IFU_REQ:  state_d = hs ? IFU_WAIT : IFU_REQ;
        IFU_WAIT: if (bus.resp_valid_i) begin
          inst_d   = bus.resp_data_i;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = IFU_OUT;
        end
        IFU_DROP: state_d = bus.resp_valid_i ? IFU_REQ : IFU_DROP;
        IFU_OUT:  if (bus.ready_i) begin
          valid_d = 1'b0;
          state_d = IFU_REQ;
        end
        default:  state_d = IFU_REQ;
      endcase
    end
  end
  // state, PC and decode-facing output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IFU_REQ;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end
  assign bus.req_valid_o = (state_q == IFU_REQ);
  assign bus.req_addr_o  = pc_q;
  assign bus.inst_o      = inst_q;
  assign bus.pc_o        = pc_out_q;
  assign bus.valid_o     = valid_q;
endmodule
